// File: rtl/ycbcr422_capture_packer.sv
// ycbcr422_capture_packer: RGB pixels -> YCbCr 4:2:2 words tagged {x_block, line}, one FIFO write per active pixel.
// Latency: o_fifo_wr 3 cycles after i_de is sampled high (4 cycles when CHROMA_AVG_EN is defined).
// Backpressure: never stalls the video path; a word meeting i_fifo_full is dropped, counted and flagged sticky.
module ycbcr422_capture_packer #(
    parameter int HALF_WIDTH = 640,
    parameter bit VSYNC_POL  = 1'b1
) (
    input  logic        i_clk_74M,
    input  logic        i_rst,
    input  logic        i_de,
    input  logic        i_vsync,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    input  logic        i_fifo_full,
    output logic [28:0] o_fifo_din,
    output logic        o_fifo_wr,
    output logic        o_overflow,
    output logic [15:0] o_drop_cnt
);

    typedef struct packed {
        logic [1:0]  xb;
        logic [10:0] line;
        logic        odd;
    } tag_t;

    localparam logic [13:0] XB1 = 14'(HALF_WIDTH);
    localparam logic [13:0] XB2 = 14'(2 * HALF_WIDTH);
    localparam logic [13:0] XB3 = 14'(3 * HALF_WIDTH);

    logic        de_d, vs_d, armed, blk3;
    logic [11:0] pixel_x;
    logic [10:0] line_cnt;
    logic        vs_act, de_rise, de_fall, vs_edge, blk3_cur, xb3;
    logic [11:0] cur_x;
    logic [13:0] cur_x14;
    tag_t        in_tag;

    // Edge detection and tag of the pixel currently on the inputs
    always_comb begin
        in_tag   = '0;
        vs_act   = (i_vsync == VSYNC_POL);
        de_rise  = i_de & ~de_d;
        de_fall  = ~i_de & de_d;
        vs_edge  = vs_act & ~vs_d;
        cur_x    = de_rise ? 12'd0 : pixel_x;
        cur_x14  = {2'b00, cur_x};
        // block 3 is sticky within a line so a wrapped pixel_x cannot fall back to block 0
        blk3_cur = de_rise ? 1'b0 : blk3;
        xb3      = blk3_cur | (cur_x14 >= XB3);
        in_tag.line = line_cnt;
        in_tag.odd  = cur_x[0];
        if (xb3)                  in_tag.xb = 2'd3;
        else if (cur_x14 >= XB2)  in_tag.xb = 2'd2;
        else if (cur_x14 >= XB1)  in_tag.xb = 2'd1;
        else                      in_tag.xb = 2'd0;
    end

    // Pixel/line counters and arming; the line counter runs even while disarmed
    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            de_d     <= 1'b0;
            vs_d     <= 1'b0;
            armed    <= 1'b0;
            blk3     <= 1'b0;
            pixel_x  <= 12'd0;
            line_cnt <= 11'd0;
        end else begin
            de_d <= i_de;
            vs_d <= vs_act;
            if (!i_de) armed <= 1'b1;
            if (i_de) begin
                pixel_x <= cur_x + 12'd1;
                blk3    <= xb3;
            end
            if (vs_edge)      line_cnt <= 11'd0;
            else if (de_fall) line_cnt <= line_cnt + 11'd1;
        end
    end

    // S1: register pixel and tag
    logic       s1_vld;
    logic [7:0] s1_r, s1_g, s1_b;
    tag_t       s1_tag;
    always_ff @(posedge i_clk_74M) begin
        s1_r   <= i_r;
        s1_g   <= i_g;
        s1_b   <= i_b;
        s1_tag <= in_tag;
        if (i_rst) s1_vld <= 1'b0;
        else       s1_vld <= i_de & armed;
    end

    function automatic logic signed [17:0] mul(input logic [7:0] k, input logic [7:0] v);
        return $signed({10'd0, k}) * $signed({10'd0, v});
    endfunction

    // S2: coefficient products (magnitudes; signs applied in the sums)
    logic              s2_vld;
    tag_t              s2_tag;
    logic signed [17:0] s2_yr, s2_yg, s2_yb, s2_br, s2_bg, s2_bb, s2_rr, s2_rg, s2_rb;
    always_ff @(posedge i_clk_74M) begin
        s2_tag <= s1_tag;
        s2_yr  <= mul(8'd66,  s1_r);
        s2_yg  <= mul(8'd129, s1_g);
        s2_yb  <= mul(8'd25,  s1_b);
        s2_br  <= mul(8'd38,  s1_r);
        s2_bg  <= mul(8'd74,  s1_g);
        s2_bb  <= mul(8'd112, s1_b);
        s2_rr  <= mul(8'd112, s1_r);
        s2_rg  <= mul(8'd94,  s1_g);
        s2_rb  <= mul(8'd18,  s1_b);
        if (i_rst) s2_vld <= 1'b0;
        else       s2_vld <= s1_vld;
    end

    function automatic logic [7:0] clamp8(input logic signed [17:0] sum, input logic signed [17:0] offs);
        logic signed [17:0] v;
        v = (sum >>> 8) + offs;
        if (v < 18'sd0)        return 8'd0;
        else if (v > 18'sd255) return 8'd255;
        else                   return v[7:0];
    endfunction

    // S3: sum with rounding constant, floor shift, offset and clamp
    logic       s3_vld;
    tag_t       s3_tag;
    logic [7:0] s3_y, s3_cb, s3_cr;
    always_ff @(posedge i_clk_74M) begin
        s3_tag <= s2_tag;
        s3_y   <= clamp8(s2_yr + s2_yg + s2_yb + 18'sd128, 18'sd16);
        s3_cb  <= clamp8(s2_bb - s2_br - s2_bg + 18'sd128, 18'sd128);
        s3_cr  <= clamp8(s2_rr - s2_rg - s2_rb + 18'sd128, 18'sd128);
        if (i_rst) s3_vld <= 1'b0;
        else       s3_vld <= s2_vld;
    end

    logic        pk_vld;
    logic [28:0] pk_word;

`ifdef CHROMA_AVG_EN
    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

    // S3b: one extra stage so an even pixel can see its odd partner still in S3
    logic       s3b_vld;
    tag_t       s3b_tag;
    logic [7:0] s3b_y, s3b_cb, s3b_cr, prev_cb;
    always_ff @(posedge i_clk_74M) begin
        s3b_tag <= s3_tag;
        s3b_y   <= s3_y;
        s3b_cb  <= s3_cb;
        s3b_cr  <= s3_cr;
        if (s3b_vld) prev_cb <= s3b_cb;
        if (i_rst) s3b_vld <= 1'b0;
        else       s3b_vld <= s3_vld;
    end

    // Even word averages Cr with the following odd pixel; odd word averages Cb with the preceding even one.
    // An even pixel with no odd pixel behind it (end of line) keeps its own Cr.
    logic [7:0] pk_c;
    always_comb begin
        pk_c = s3b_cr;
        if (s3b_tag.odd)                pk_c = avg8(prev_cb, s3b_cb);
        else if (s3_vld && s3_tag.odd)  pk_c = avg8(s3b_cr, s3_cr);
        pk_vld  = s3b_vld;
        pk_word = {s3b_tag.xb, s3b_tag.line, s3b_y, pk_c};
    end
`else
    // Co-sited decimation: even pixels carry Cr, odd pixels carry Cb
    always_comb begin
        pk_vld  = s3_vld;
        pk_word = {s3_tag.xb, s3_tag.line, s3_y, s3_tag.odd ? s3_cb : s3_cr};
    end
`endif

    // S4: present the word and write it, or drop and account for it when the FIFO is full
    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            o_fifo_din <= 29'd0;
            o_fifo_wr  <= 1'b0;
            o_overflow <= 1'b0;
            o_drop_cnt <= 16'd0;
        end else begin
            o_fifo_wr <= pk_vld & ~i_fifo_full;
            if (pk_vld) o_fifo_din <= pk_word;
            if (pk_vld && i_fifo_full) begin
                o_overflow <= 1'b1;
                if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ycbcr422_capture_packer.sv
// tb_ycbcr422_capture_packer: directed lines of pixels, written words collected and checked against hand values.
// Latency: expected first write LAT+1 bench cycles after the first pixel is driven.
// Backpressure: fifo_full is raised for selected words to exercise the drop path.
module tb_ycbcr422_capture_packer;

`ifdef CHROMA_AVG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int NODROP  = -1000;
    localparam int M_BLACK = 0;
    localparam int M_WHITE = 1;
    localparam int M_RED   = 2;
    localparam int M_GRAY  = 3;
    localparam int M_RB    = 4;

    logic        clk = 1'b0;
    logic        rst, de, vsync, fifo_full;
    logic [7:0]  r, g, b;
    logic [28:0] fifo_din;
    logic        fifo_wr, overflow;
    logic [15:0] drop_cnt;

    int cyc = 0;
    int first_cyc = 0;
    int n_pass = 0;
    int n_chk = 0;
    logic [28:0] wq[$];
    int          wq_cyc[$];

    ycbcr422_capture_packer dut (
        .i_clk_74M   (clk),
        .i_rst       (rst),
        .i_de        (de),
        .i_vsync     (vsync),
        .i_r         (r),
        .i_g         (g),
        .i_b         (b),
        .i_fifo_full (fifo_full),
        .o_fifo_din  (fifo_din),
        .o_fifo_wr   (fifo_wr),
        .o_overflow  (overflow),
        .o_drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // collect every written word away from the active edge
    always @(negedge clk) begin
        if (fifo_wr) begin
            wq.push_back(fifo_din);
            wq_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] xb_of(input int p);
        if (p < 640)  return 2'd0;
        if (p < 1280) return 2'd1;
        if (p < 1920) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [7:0] y_of(input int mode, input int p);
        int gv;
        gv = (p * 8) % 256;
        case (mode)
            M_WHITE: return 8'd235;
            M_RED:   return 8'd82;
            M_GRAY:  return 8'(((220 * gv + 128) >> 8) + 16);
            M_RB:    return (p % 2 == 0) ? 8'd82 : 8'd16;
            default: return 8'd16;
        endcase
    endfunction

    function automatic logic [7:0] c_of(input int mode, input int p, input int n);
        case (mode)
            M_RED: return (p % 2 == 0) ? 8'd240 : 8'd90;
`ifdef CHROMA_AVG_EN
            M_RB:  return (p % 2 == 1) ? 8'd109 : ((p + 1 < n) ? 8'd184 : 8'd240);
`else
            M_RB:  return (p % 2 == 1) ? 8'd128 : 8'd240;
`endif
            default: return 8'd128;
        endcase
    endfunction

    function automatic logic [28:0] word_at(input int j);
        if (j < wq.size()) return wq[j];
        return '1;
    endfunction

    function automatic int bad_words(input int n, input int mode, input int ln, input int dlo, input int dhi);
        int k;
        int bad;
        logic [28:0] e;
        k = 0;
        bad = 0;
        for (int p = 0; p < n; p++) begin
            if (p >= dlo && p <= dhi) continue;
            e = {xb_of(p), 11'(ln), y_of(mode, p), c_of(mode, p, n)};
            if (k >= wq.size() || wq[k] !== e) bad++;
            k++;
        end
        return bad;
    endfunction

    function automatic int first_lat();
        if (wq_cyc.size() == 0) return -1;
        return wq_cyc[0] - first_cyc;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            de = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0; fifo_full = 1'b0;
        end
    endtask

    task automatic set_rgb(input int mode, input int p);
        case (mode)
            M_WHITE: begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
            M_RED:   begin r = 8'hFF; g = 8'h00; b = 8'h00; end
            M_GRAY:  begin r = 8'(p * 8); g = 8'(p * 8); b = 8'(p * 8); end
            M_RB:    begin r = (p % 2 == 0) ? 8'hFF : 8'h00; g = 8'h00; b = 8'h00; end
            default: begin r = 8'h00; g = 8'h00; b = 8'h00; end
        endcase
    endtask

    // words dlo..dhi meet a full FIFO: the flag must be up while pixel j+LAT is on the inputs
    task automatic drive_line(input int n, input int mode, input int dlo, input int dhi);
        for (int p = 0; p < n; p++) begin
            @(posedge clk); #1;
            de = 1'b1;
            set_rgb(mode, p);
            fifo_full = (p >= dlo + LAT) && (p <= dhi + LAT);
            if (p == 0) first_cyc = cyc;
        end
    endtask

    logic [28:0] w;

    initial begin
        rst = 1'b1; de = 1'b0; vsync = 1'b0; fifo_full = 1'b0;
        r = 8'd0; g = 8'd0; b = 8'd0;
        idle(3);
        @(negedge clk);
        check("reset_din", 32'(fifo_din), 32'd0);
        check("reset_wr", 32'(fifo_wr), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle(3);

        // 1280 black pixels on line 0
        wq.delete(); wq_cyc.delete();
        drive_line(1280, M_BLACK, NODROP, NODROP); idle(10);
        check("black_count", 32'(wq.size()), 32'd1280);
        check("black_latency", 32'(first_lat()), 32'(LAT + 1));
        check("black_words_bad", 32'(bad_words(1280, M_BLACK, 0, NODROP, NODROP)), 32'd0);
        w = word_at(639); check("word639_xblock", 32'(w[28:27]), 32'd0);
        w = word_at(640); check("word640_xblock", 32'(w[28:27]), 32'd1);

        // VSYNC resets the line count
        vsync = 1'b1; idle(2); vsync = 1'b0; idle(3);
        wq.delete(); wq_cyc.delete();
        drive_line(6, M_WHITE, NODROP, NODROP); idle(10);
        check("white_count", 32'(wq.size()), 32'd6);
        check("white_words_bad", 32'(bad_words(6, M_WHITE, 0, NODROP, NODROP)), 32'd0);

        // odd-length red line on line 1
        wq.delete(); wq_cyc.delete();
        drive_line(5, M_RED, NODROP, NODROP); idle(10);
        check("red_count", 32'(wq.size()), 32'd5);
        check("red_words_bad", 32'(bad_words(5, M_RED, 1, NODROP, NODROP)), 32'd0);
        w = word_at(4); check("red_last_c", 32'(w[7:0]), 32'd240);

        drive_line(4, M_BLACK, NODROP, NODROP); idle(5);
        wq.delete(); wq_cyc.delete();
        drive_line(4, M_BLACK, NODROP, NODROP); idle(10);
        w = word_at(0); check("line3_tag", 32'(w[26:16]), 32'd3);

        // line 4 ends with DE fall and VSYNC edge in the same cycle
        wq.delete(); wq_cyc.delete();
        drive_line(4, M_BLACK, NODROP, NODROP);
        @(posedge clk); #1 de = 1'b0; vsync = 1'b1;
        idle(2); vsync = 1'b0; idle(6);
        w = word_at(0); check("line4_tag", 32'(w[26:16]), 32'd4);
        wq.delete(); wq_cyc.delete();
        drive_line(4, M_BLACK, NODROP, NODROP); idle(10);
        w = word_at(0); check("coincident_clear_tag", 32'(w[26:16]), 32'd0);

        // gray ramp with words 10..14 dropped, line 1
        wq.delete(); wq_cyc.delete();
        drive_line(32, M_GRAY, 10, 14); idle(10);
        check("drop_count_words", 32'(wq.size()), 32'd27);
        check("drop_words_bad", 32'(bad_words(32, M_GRAY, 1, 10, 14)), 32'd0);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_cnt", 32'(drop_cnt), 32'd5);

        wq.delete(); wq_cyc.delete();
        drive_line(4, M_BLACK, NODROP, NODROP); idle(10);
        check("after_drop_count", 32'(wq.size()), 32'd4);
        check("overflow_sticky", 32'(overflow), 32'd1);
        check("drop_cnt_held", 32'(drop_cnt), 32'd5);

        // reset asserted mid-line and released while DE is still high
        for (int p = 0; p < 40; p++) begin
            @(posedge clk); #1;
            de = 1'b1; r = 8'd0; g = 8'd0; b = 8'd0; fifo_full = 1'b0;
            rst = (p == 10 || p == 11);
            if (p == 12) begin wq.delete(); wq_cyc.delete(); end
        end
        idle(10);
        check("rst_midline_writes", 32'(wq.size()), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        wq.delete(); wq_cyc.delete();
        drive_line(8, M_BLACK, NODROP, NODROP); idle(10);
        check("after_rst_count", 32'(wq.size()), 32'd8);
        check("after_rst_words_bad", 32'(bad_words(8, M_BLACK, 1, NODROP, NODROP)), 32'd0);

        // red, black, red on line 2
        wq.delete(); wq_cyc.delete();
        drive_line(3, M_RB, NODROP, NODROP); idle(10);
        check("rb_count", 32'(wq.size()), 32'd3);
        check("rb_latency", 32'(first_lat()), 32'(LAT + 1));
        check("rb_words_bad", 32'(bad_words(3, M_RB, 2, NODROP, NODROP)), 32'd0);
        w = word_at(2); check("rb_last_c", 32'(w[7:0]), 32'd240);

        // 4100-pixel line on line 3: pixel_x wraps, block stays 3
        wq.delete(); wq_cyc.delete();
        drive_line(4100, M_BLACK, NODROP, NODROP); idle(10);
        check("long_count", 32'(wq.size()), 32'd4100);
        check("long_words_bad", 32'(bad_words(4100, M_BLACK, 3, NODROP, NODROP)), 32'd0);
        w = word_at(4096); check("wrap_xblock", 32'(w[28:27]), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
